// File: rtl/cook_ctrl_pkg.sv
// cook_ctrl_pkg: shared state codes, BCD limit and state width for the cooker controller
package cook_ctrl_pkg;
    localparam int STATE_W = 3;
    localparam logic [3:0] BCD_MAX = 4'd9;
    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;
endpackage

// File: rtl/beep_gen.sv
// beep_gen: times the end-of-cook beep; busy is high while more beep cycles follow the current one
module beep_gen #(
    parameter int BEEP_CYCLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    output logic busy
);
    localparam int CW = $clog2(BEEP_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(BEEP_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    assign busy = cnt_q != '0 && cnt_q < CMAX;
    // count elapsed beep cycles, saturating at BEEP_CYCLES
    always_comb begin
        cnt_d = trigger ? CW'(1) : busy ? cnt_q + 1'b1 : cnt_q;
    end
    // counter register
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cook_ctrl.sv
// cook_ctrl: microwave keypad/door/timer controller FSM with registered outputs
module cook_ctrl
    import cook_ctrl_pkg::*;
#(
    parameter int BEEP_CYCLES = 3,
    parameter int MAX_DIGITS  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [3:0]         key_digit,
    input  logic               start,
    input  logic               stop_clear,
    input  logic               door_closed,
    input  logic               timer_zero,
    output logic               timer_loadn,
    output logic               timer_clearn,
    output logic [3:0]         timer_data,
    output logic               timer_enable,
    output logic               mag_on,
    output logic               done_beep,
    output logic [STATE_W-1:0] state
);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    state_t state_q, state_d;
    logic [DW-1:0] digit_count_q, digit_count_d;
    logic loadn_q, loadn_d, clearn_q, clearn_d;
    logic [3:0] data_q, data_d;
    logic enable_q, enable_d, mag_q, mag_d, beep_q, beep_d;
    logic key_ok, clear, beep_busy;
    assign key_ok = key_valid && key_digit <= BCD_MAX && digit_count_q < DW'(MAX_DIGITS);
    assign timer_loadn  = loadn_q;
    assign timer_clearn = clearn_q;
    assign timer_data   = data_q;
    assign timer_enable = enable_q;
    assign mag_on       = mag_q;
    assign done_beep    = beep_q;
    assign state        = state_q;
    beep_gen #(.BEEP_CYCLES(BEEP_CYCLES)) u_beep (
        .clock   (clock),
        .reset   (reset),
        .trigger (state_q == COOKING && state_d == DONE),
        .busy    (beep_busy)
    );
    // next state and next outputs; outputs follow the state being entered
    always_comb begin
        state_d       = state_q;
        digit_count_d = digit_count_q;
        loadn_d       = 1'b1;
        clearn_d      = 1'b1;
        data_d        = data_q;
        clear         = 1'b0;
        case (state_q)
            IDLE, ENTRY: begin
                if (stop_clear) clear = 1'b1;
                else if (state_q == ENTRY && start && door_closed && !timer_zero) state_d = COOKING;
                else if (key_ok) begin
                    state_d       = ENTRY;
                    loadn_d       = 1'b0;
                    data_d        = key_digit;
                    digit_count_d = digit_count_q + 1'b1;
                end
            end
            COOKING: begin
                if (timer_zero) state_d = DONE;
                else if (!door_closed || stop_clear) state_d = PAUSED;
            end
            PAUSED: begin
                if (stop_clear) clear = 1'b1;
                else if (start && door_closed) state_d = COOKING;
            end
            DONE:    clear = stop_clear || !beep_busy;
            default: clear = 1'b1;
        endcase
        if (clear) begin
            state_d       = IDLE;
            digit_count_d = '0;
            clearn_d      = 1'b0;
        end
        enable_d = state_d == COOKING;
        mag_d    = state_d == COOKING;
        beep_d   = state_d == DONE;
    end
    // state and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            digit_count_q <= '0;
            loadn_q       <= 1'b1;
            clearn_q      <= 1'b0;
            data_q        <= 4'd0;
            enable_q      <= 1'b0;
            mag_q         <= 1'b0;
            beep_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_count_q <= digit_count_d;
            loadn_q       <= loadn_d;
            clearn_q      <= clearn_d;
            data_q        <= data_d;
            enable_q      <= enable_d;
            mag_q         <= mag_d;
            beep_q        <= beep_d;
        end
    end
endmodule
